alu_checker: RTL and testbench

Self-checking response end for the single-cycle ALU: it consumes the `{rs, rt, ALUop}` stimulus together with the ALU's `result` and `equal` outputs, recomputes the golden values, and keeps pass, fail and skip statistics. It also captures the first mismatch. It sits beside the ALU inside the single_cpu verification harness and can stay in silicon as a bring-up monitor.

---
 rtl/alu_checker_pkg.sv | 19 +
 rtl/alu_checker_golden.sv | 29 ++
 rtl/alu_checker.sv | 204 ++++++++++++++++++++
 tb/tb_alu_checker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_checker_pkg.sv
// Shared definitions for the ALU response checker: opcodes and checker states.
package alu_checker_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_LUI = 3'd4;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_checker_golden.sv
// Combinational reference model of the single-cycle ALU.
// chk is low for reserved opcodes, which are never compared.
module alu_golden
  import alu_checker_pkg::*;
(
  input  logic [WORD_W-1:0] rs,
  input  logic [WORD_W-1:0] rt,
  input  logic [2:0]        alu_op,
  output logic [WORD_W-1:0] exp_result,
  output logic              exp_equal,
  output logic              chk
);

  // Expected result, equality flag and check-enable per opcode.
  always_comb begin
    exp_result = '0;
    chk        = 1'b1;
    exp_equal  = (rs == rt);
    case (alu_op)
      ALU_ADD: exp_result = rs + rt;
      ALU_SUB: exp_result = rs - rt;
      ALU_OR:  exp_result = rs | rt;
      ALU_AND: exp_result = rs & rt;
      ALU_LUI: exp_result = {rt[15:0], 16'h0000};
      default: chk = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_checker.sv
// Self-checking response monitor for the single-cycle ALU. Stage 1 captures
// the stimulus and the ALU response; stage 2 compares against alu_golden and
// updates pass/fail/skip statistics and the first-failure record.
module alu_checker
  import alu_checker_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter bit HALT_ON_FAIL = 1'b0
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              valid,
  input  logic [WORD_W-1:0] rs,
  input  logic [WORD_W-1:0] rt,
  input  logic [2:0]        alu_op,
  input  logic [WORD_W-1:0] result,
  input  logic              equal,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [CNT_W-1:0]  skip_cnt,
  output logic [CNT_W-1:0]  ff_idx,
  output logic [2:0]        ff_op,
  output logic [WORD_W-1:0] ff_exp,
  output logic [WORD_W-1:0] ff_got
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  state_e state_q, state_d;

  logic              vld_p1_q, vld_p1_d;
  logic [WORD_W-1:0] rs_p1_q, rs_p1_d;
  logic [WORD_W-1:0] rt_p1_q, rt_p1_d;
  logic [2:0]        op_p1_q, op_p1_d;
  logic [WORD_W-1:0] res_p1_q, res_p1_d;
  logic              eq_p1_q, eq_p1_d;

  logic [WORD_W-1:0] exp_result_p1;
  logic              exp_equal_p1;
  logic              chk_p1;
  logic              accept;
  logic              mismatch_p1;
  logic              fail_p1;

  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [CNT_W-1:0]  fail_q, fail_d;
  logic [CNT_W-1:0]  skip_q, skip_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  ff_idx_q, ff_idx_d;
  logic [2:0]        ff_op_q, ff_op_d;
  logic [WORD_W-1:0] ff_exp_q, ff_exp_d;
  logic [WORD_W-1:0] ff_got_q, ff_got_d;

  // start flushes the pipeline, so a sample coincident with start is dropped.
  assign accept = (state_q == S_RUN) && valid && !start;

  // ---- stage 1: capture stimulus and response on the accept edge ----

  // Load the stage-1 registers only when a sample is accepted.
  always_comb begin
    vld_p1_d = accept;
    rs_p1_d  = rs_p1_q;
    rt_p1_d  = rt_p1_q;
    op_p1_d  = op_p1_q;
    res_p1_d = res_p1_q;
    eq_p1_d  = eq_p1_q;
    if (accept) begin
      rs_p1_d  = rs;
      rt_p1_d  = rt;
      op_p1_d  = alu_op;
      res_p1_d = result;
      eq_p1_d  = equal;
    end
  end

  // Stage-1 data registers; only the valid bit needs a reset value.
  always_ff @(posedge clk) begin
    rs_p1_q  <= rs_p1_d;
    rt_p1_q  <= rt_p1_d;
    op_p1_q  <= op_p1_d;
    res_p1_q <= res_p1_d;
    eq_p1_q  <= eq_p1_d;
  end

  // ---- stage 2: compare against the reference and update statistics ----

  alu_golden u_golden (
    .rs         (rs_p1_q),
    .rt         (rt_p1_q),
    .alu_op     (op_p1_q),
    .exp_result (exp_result_p1),
    .exp_equal  (exp_equal_p1),
    .chk        (chk_p1)
  );

  assign mismatch_p1 = (res_p1_q != exp_result_p1) || (eq_p1_q != exp_equal_p1);
  assign fail_p1     = vld_p1_q && chk_p1 && mismatch_p1;

  // Counter, sticky-error and first-failure updates; start clears everything.
  always_comb begin
    pass_d   = pass_q;
    fail_d   = fail_q;
    skip_d   = skip_q;
    idx_d    = idx_q;
    err_d    = err_q;
    ff_idx_d = ff_idx_q;
    ff_op_d  = ff_op_q;
    ff_exp_d = ff_exp_q;
    ff_got_d = ff_got_q;
    if (start) begin
      pass_d   = '0;
      fail_d   = '0;
      skip_d   = '0;
      idx_d    = '0;
      err_d    = 1'b0;
      ff_idx_d = '0;
      ff_op_d  = '0;
      ff_exp_d = '0;
      ff_got_d = '0;
    end else if (vld_p1_q) begin
      idx_d = sat_inc(idx_q);
      if (!chk_p1) begin
        skip_d = sat_inc(skip_q);
      end else if (mismatch_p1) begin
        fail_d = sat_inc(fail_q);
        if (!err_q) begin
          err_d    = 1'b1;
          ff_idx_d = idx_q;
          ff_op_d  = op_p1_q;
          ff_exp_d = exp_result_p1;
          ff_got_d = res_p1_q;
        end
      end else begin
        pass_d = sat_inc(pass_q);
      end
    end
  end

  // Next-state logic: start always wins and restarts into RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        if (start)                              state_d = S_RUN;
        else if (stop || (HALT_ON_FAIL && fail_p1)) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = start ? S_RUN : S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and statistics registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      vld_p1_q <= 1'b0;
      pass_q   <= '0;
      fail_q   <= '0;
      skip_q   <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      ff_idx_q <= '0;
      ff_op_q  <= '0;
      ff_exp_q <= '0;
      ff_got_q <= '0;
    end else begin
      state_q  <= state_d;
      vld_p1_q <= vld_p1_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      skip_q   <= skip_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      ff_idx_q <= ff_idx_d;
      ff_op_q  <= ff_op_d;
      ff_exp_q <= ff_exp_d;
      ff_got_q <= ff_got_d;
    end
  end

  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign skip_cnt = skip_q;
  assign ff_idx   = ff_idx_q;
  assign ff_op    = ff_op_q;
  assign ff_exp   = ff_exp_q;
  assign ff_got   = ff_got_q;

endmodule

// File: tb/tb_alu_checker.sv
// Testbench for alu_checker: default, halt-on-fail and narrow-counter instances.
module tb_alu_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  start_v = 3'b000;
  logic        stop = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] rs = '0, rt = '0, result = '0;
  logic [2:0]  alu_op = '0;
  logic        equal = 1'b0;

  always #5 clk = ~clk;

  logic        a_busy, a_done, a_err;
  logic [15:0] a_pass, a_fail, a_skip, a_ff_idx;
  logic [2:0]  a_ff_op;
  logic [31:0] a_ff_exp, a_ff_got;

  logic        h_busy, h_done, h_err;
  logic [15:0] h_pass, h_fail, h_skip, h_ff_idx;
  logic [2:0]  h_ff_op;
  logic [31:0] h_ff_exp, h_ff_got;

  logic        s_busy, s_done, s_err;
  logic [3:0]  s_pass, s_fail, s_skip, s_ff_idx;
  logic [2:0]  s_ff_op;
  logic [31:0] s_ff_exp, s_ff_got;

  alu_checker u_dut (
    .clk(clk), .reset(reset), .start(start_v[0]), .stop(stop), .valid(valid),
    .rs(rs), .rt(rt), .alu_op(alu_op), .result(result), .equal(equal),
    .busy(a_busy), .done(a_done), .err(a_err),
    .pass_cnt(a_pass), .fail_cnt(a_fail), .skip_cnt(a_skip),
    .ff_idx(a_ff_idx), .ff_op(a_ff_op), .ff_exp(a_ff_exp), .ff_got(a_ff_got)
  );

  alu_checker #(.HALT_ON_FAIL(1'b1)) u_halt (
    .clk(clk), .reset(reset), .start(start_v[1]), .stop(stop), .valid(valid),
    .rs(rs), .rt(rt), .alu_op(alu_op), .result(result), .equal(equal),
    .busy(h_busy), .done(h_done), .err(h_err),
    .pass_cnt(h_pass), .fail_cnt(h_fail), .skip_cnt(h_skip),
    .ff_idx(h_ff_idx), .ff_op(h_ff_op), .ff_exp(h_ff_exp), .ff_got(h_ff_got)
  );

  alu_checker #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .start(start_v[2]), .stop(stop), .valid(valid),
    .rs(rs), .rt(rt), .alu_op(alu_op), .result(result), .equal(equal),
    .busy(s_busy), .done(s_done), .err(s_err),
    .pass_cnt(s_pass), .fail_cnt(s_fail), .skip_cnt(s_skip),
    .ff_idx(s_ff_idx), .ff_op(s_ff_op), .ff_exp(s_ff_exp), .ff_got(s_ff_got)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard of expected counter values for u_dut, due at a given cycle.
  typedef struct {
    int due;
    int p;
    int f;
    int s;
  } sb_t;
  sb_t sb_q[$];
  int  exp_p = 0, exp_f = 0, exp_s = 0;
  bit  a_run = 1'b0;

  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a | b;
      3'd3:    return a & b;
      3'd4:    return {b[15:0], 16'h0000};
      default: return 32'h0;
    endcase
  endfunction

  // Drive one valid sample; xr corrupts result bits, fe flips the equal flag.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [31:0] xr, input logic fe, input logic st);
    rs     = a;
    rt     = b;
    alu_op = op;
    result = ref_result(a, b, op) ^ xr;
    equal  = (a == b) ^ fe;
    valid  = 1'b1;
    stop   = st;
    if (a_run) begin
      if (op > 3'd4)               exp_s++;
      else if (xr != 0 || fe)      exp_f++;
      else                         exp_p++;
      sb_q.push_back('{cyc + 2, exp_p, exp_f, exp_s});
      if (st) a_run = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    valid   = 1'b0;
    stop    = 1'b0;
    start_v = 3'b000;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input int k);
    valid      = 1'b0;
    stop       = 1'b0;
    start_v[k] = 1'b1;
    if (k == 0) begin
      a_run = 1'b1;
      exp_p = 0;
      exp_f = 0;
      exp_s = 0;
    end
    @(negedge clk);
    start_v = 3'b000;
  endtask

  // Pop and compare scoreboard entries as the statistics become visible.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      sb_t e;
      e = sb_q.pop_front();
      check("sb_pass", a_pass, e.p);
      check("sb_fail", a_fail, e.f);
      check("sb_skip", a_skip, e.s);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_err",  a_err, 0);
    check("rst_pass", a_pass, 0);
    reset = 1'b1;
    idle(1);

    // Basic passing run, last sample carries stop.
    do_start(0);
    check("run_busy", a_busy, 1);
    drive(32'd20, 32'd10, 3'd0, 0, 0, 0);
    drive(32'd20, 32'd10, 3'd1, 0, 0, 0);
    drive(32'd1,  32'd2,  3'd2, 0, 0, 1);
    idle(3);
    check("t1_pass", a_pass, 3);
    check("t1_fail", a_fail, 0);
    check("t1_err",  a_err, 0);
    check("t1_done", a_done, 1);

    // First-failure capture at index 4, later failure must not overwrite.
    do_start(0);
    check("restart_pass", a_pass, 0);
    drive(32'hFFFF_FFFF, 32'd1, 3'd0, 0, 0, 0);
    drive(32'h1234_5678, 32'h0000_ABCD, 3'd4, 0, 0, 0);
    drive(32'h0000_F0F0, 32'h0000_0FF0, 3'd3, 0, 0, 0);
    drive(32'd9, 32'd9, 3'd2, 0, 0, 0);
    drive(32'd5, 32'd5, 3'd1, 0, 1, 0);
    idle(2);
    check("ff_err",    a_err, 1);
    check("ff_fail",   a_fail, 1);
    check("ff_idx",    a_ff_idx, 4);
    check("ff_op",     a_ff_op, 1);
    check("ff_exp",    a_ff_exp, 0);
    check("ff_got",    a_ff_got, 0);
    drive(32'd3, 32'd4, 3'd0, 32'h10, 0, 0);
    drive(32'd1, 32'd1, 3'd6, 0, 0, 0);
    drive(32'd7, 32'd8, 3'd2, 0, 0, 1);
    idle(3);
    check("ff_idx_hold", a_ff_idx, 4);
    check("ff_op_hold",  a_ff_op, 1);
    check("ff_exp_hold", a_ff_exp, 0);
    check("ff_got_hold", a_ff_got, 0);
    check("t2_fail", a_fail, 2);
    check("t2_skip", a_skip, 1);
    check("t2_pass", a_pass, 5);
    check("t2_done", a_done, 1);

    // Samples in DONE are ignored.
    drive(32'd1, 32'd2, 3'd0, 0, 0, 0);
    drive(32'd1, 32'd2, 3'd0, 32'h1, 0, 0);
    idle(2);
    check("done_ign_pass", a_pass, 5);
    check("done_ign_fail", a_fail, 2);

    // Halt-on-fail: one pass, a mismatch, then four more samples.
    do_start(1);
    drive(32'd1, 32'd1, 3'd0, 0, 0, 0);
    drive(32'd2, 32'd3, 3'd0, 32'h1, 0, 0);
    for (int i = 0; i < 4; i++) drive(32'(i), 32'd7, 3'd2, 0, 0, 0);
    idle(4);
    check("halt_done", h_done, 1);
    check("halt_err",  h_err, 1);
    check("halt_fail", h_fail, 1);
    check("halt_pass", h_pass, 2);
    check("halt_idx",  h_ff_idx, 1);

    // Saturation with 4-bit counters.
    do_start(2);
    for (int i = 0; i < 20; i++) drive(32'(i * 3), 32'(i + 1), 3'd0, 0, 0, 0);
    idle(2);
    check("sat_pass", s_pass, 15);
    check("sat_fail", s_fail, 0);
    check("sat_busy", s_busy, 1);

    // Asynchronous reset with samples in flight.
    do_start(0);
    drive(32'd4, 32'd4, 3'd3, 0, 0, 0);
    drive(32'd4, 32'd5, 3'd2, 0, 0, 0);
    drive(32'd6, 32'd5, 3'd1, 32'h2, 0, 0);
    valid = 1'b0;
    #2 reset = 1'b0;
    sb_q.delete();
    a_run = 1'b0;
    #1;
    check("arst_busy", a_busy, 0);
    check("arst_done", a_done, 0);
    check("arst_err",  a_err, 0);
    check("arst_pass", a_pass, 0);
    check("arst_fail", a_fail, 0);
    check("arst_skip", a_skip, 0);
    check("arst_ffidx", a_ff_idx, 0);
    check("arst_ffexp", a_ff_exp, 0);
    check("arst_s_pass", s_pass, 0);
    check("arst_h_done", h_done, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(32'd1, 32'd1, 3'd0, 0, 0, 0);
    drive(32'd1, 32'd1, 3'd0, 32'h4, 0, 0);
    idle(2);
    check("post_rst_pass", a_pass, 0);
    check("post_rst_fail", a_fail, 0);
    check("post_rst_busy", a_busy, 0);
    do_start(0);
    drive(32'hDEAD_0000, 32'h0000_BEEF, 3'd4, 0, 0, 1);
    idle(3);
    check("final_pass", a_pass, 1);
    check("final_done", a_done, 1);
    check("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
